// File: rtl/xadac_pkg.sv
// Shared constants and tag-table entry type for the xadac OBI arbiter.
// Defaults describe the standard vload/vstore pairing on an 8-deep tag table.
package xadac_pkg;

    localparam int DEF_NUM_REQ  = 2;
    localparam int DEF_NUM_TAGS = 8;
    localparam int DEF_ID_W     = 4;
    localparam int DEF_TAG_W    = $clog2(DEF_NUM_TAGS);
    localparam int DEF_SRC_W    = $clog2(DEF_NUM_REQ);

    typedef struct packed {
        logic                 valid;
        logic [DEF_SRC_W-1:0] src;
        logic [DEF_ID_W-1:0]  aid;
    } tag_entry_t;

endpackage

// File: rtl/xadac_obi_arb_if.sv
// OBI bundle with N parallel A/R lanes; rdata/rid are shared by all lanes.
// The master modport issues requests, the slave modport answers them.
interface xadac_obi_arb_if #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 4
);
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [AW-1:0]   addr  [N];
    logic [DW/8-1:0] be    [N];
    logic [DW-1:0]   wdata [N];
    logic [IW-1:0]   aid   [N];
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [N-1:0]    rready;
    logic [DW-1:0]   rdata;
    logic [IW-1:0]   rid;

    modport master (
        output req, we, addr, be, wdata, aid, rready,
        input  gnt, rvalid, rdata, rid
    );

    modport slave (
        input  req, we, addr, be, wdata, aid, rready,
        output gnt, rvalid, rdata, rid
    );
endinterface

// File: rtl/xadac_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping to the lowest set request below it.
module xadac_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int W = $clog2(N);

    logic         hi_any;
    logic         lo_any;
    logic [W-1:0] hi_idx;
    logic [W-1:0] lo_idx;

    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!hi_any && req[i] && i >= int'(ptr)) begin
                hi_any = 1'b1;
                hi_idx = W'(i);
            end
            if (!lo_any && req[i]) begin
                lo_any = 1'b1;
                lo_idx = W'(i);
            end
        end
        idx      = hi_any ? hi_idx : lo_idx;
        any      = lo_any;
        gnt      = '0;
        gnt[idx] = lo_any;
    end
endmodule

// File: rtl/xadac_obi_arb.sv
// Round-robin arbiter sharing one OBI manager port among xadac memory units,
// remapping requester ids to local tags and routing responses back by tag.
module xadac_obi_arb
    import xadac_pkg::*;
#(
    parameter int NumReq    = DEF_NUM_REQ,
    parameter int NumTags   = DEF_NUM_TAGS,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = DEF_ID_W
) (
    input  logic            clk,
    input  logic            rst,
    xadac_obi_arb_if.slave  s,
    xadac_obi_arb_if.master m,
    output logic            err
);
    localparam int TagW = $clog2(NumTags);
    localparam int SrcW = $clog2(NumReq);

    typedef struct packed {
        logic               valid;
        logic [SrcW-1:0]    src;
        logic [IdWidth-1:0] aid;
    } entry_t;

    entry_t          tbl_q [NumTags];
    logic [SrcW-1:0] rr_ptr_q;
    logic [SrcW-1:0] sel_q;
    logic [TagW-1:0] tag_q;
    logic            locked_q;
    logic            err_q;

    logic [NumReq-1:0]    pick_gnt;
    logic [SrcW-1:0]      pick_idx;
    logic                 pick_any;
    logic [TagW-1:0]      free_tag;
    logic                 full;
    logic [SrcW-1:0]      sel;
    logic [TagW-1:0]      tag;
    logic [NumReq-1:0]    sel_oh;
    logic                 active;
    logic                 grant;
    logic [AddrWidth-1:0] a_addr;
    logic [DataWidth-1:0] a_wdata;
    entry_t               rsp_e;
    logic                 rsp_fire;

    xadac_rr_pick #(.N(NumReq)) u_pick (
        .req (s.req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        full     = 1'b1;
        free_tag = '0;
        for (int i = 0; i < NumTags; i++) begin
            if (full && !tbl_q[i].valid) begin
                full     = 1'b0;
                free_tag = TagW'(i);
            end
        end
    end

    // A held request keeps its requester and tag until the grant arrives.
    always_comb begin
        sel     = locked_q ? sel_q : pick_idx;
        tag     = locked_q ? tag_q : free_tag;
        sel_oh  = '0;
        sel_oh[sel] = 1'b1;
        if (!locked_q) begin
            sel_oh = pick_gnt;
        end
        active  = locked_q || (!full && pick_any);
        a_addr  = s.addr[sel];
        a_wdata = s.wdata[sel];

        m.req[0]   = active && s.req[sel];
        m.we[0]    = s.we[sel];
        m.addr[0]  = a_addr;
        m.be[0]    = s.be[sel];
        m.wdata[0] = a_wdata;
        m.aid[0]   = tag;
        grant      = m.req[0] && m.gnt[0];
        s.gnt      = grant ? sel_oh : '0;
    end

    // Responses for unknown tags are drained so the bus never stalls.
    always_comb begin
        rsp_e    = tbl_q[m.rid];
        s.rvalid = '0;
        s.rid    = rsp_e.aid;
        s.rdata  = m.rdata;
        if (rsp_e.valid) begin
            s.rvalid[rsp_e.src] = m.rvalid[0];
            m.rready[0]         = s.rready[rsp_e.src];
        end else begin
            m.rready[0] = m.rvalid[0];
        end
        rsp_fire = m.rvalid[0] && m.rready[0] && rsp_e.valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumTags; i++) begin
                tbl_q[i] <= '0;
            end
            rr_ptr_q <= '0;
            sel_q    <= '0;
            tag_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (rsp_fire) begin
                tbl_q[m.rid].valid <= 1'b0;
            end
            if (grant) begin
                tbl_q[tag] <= '{valid: 1'b1, src: sel, aid: s.aid[sel]};
                rr_ptr_q   <= (sel == SrcW'(NumReq - 1)) ? '0 : sel + 1'b1;
            end
            locked_q <= m.req[0] && !m.gnt[0];
            sel_q    <= sel;
            tag_q    <= tag;
            if (m.rvalid[0] && !rsp_e.valid) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
endmodule

// File: doc/xadac_obi_arb.md
# xadac_obi_arb

Round-robin arbiter sharing one OBI manager port among `NumReq` xadac memory units (vload, vstore, scalar fallback). Remaps each requester `aid` to a local transaction tag and routes R-channel responses back to the issuing requester with its original `aid`. Sits between the xadac load/store units and the core data-memory OBI port; A channel passes combinationally, tag bookkeeping is registered.

## Interface
Parameters:
- `NumReq`, 2, number of requester ports (≥2)
- `NumTags`, 8, outstanding-transaction table size (power of two); downstream `aid` width = `$clog2(NumTags)`
- `AddrWidth`, 32, OBI address width
- `DataWidth`, 32, OBI data width
- `IdWidth`, 4, requester-side `aid`/`rid` width

Ports (per-requester ports are `NumReq`-element unpacked arrays):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_req`, `s_we`  in  1  requester A-channel request / write enable
- `s_addr`  in  AddrWidth  requester address
- `s_be`  in  DataWidth/8  requester byte enables
- `s_wdata`  in  DataWidth  requester write data
- `s_aid`  in  IdWidth  requester transaction id
- `s_gnt`  out  1  A-channel grant to requester
- `s_rvalid`  out  1  response valid to requester
- `s_rready`  in  1  requester response ready
- `s_rdata`  out  DataWidth  response data (broadcast)
- `s_rid`  out  IdWidth  restored requester id (broadcast)
- `m_req`, `m_we`, `m_addr`, `m_be`, `m_wdata`  out  —  downstream A channel
- `m_aid`  out  $clog2(NumTags)  allocated tag
- `m_gnt`  in  1  downstream grant
- `m_rvalid`  in  1  downstream response valid
- `m_rready`  out  1  downstream response ready
- `m_rdata`  in  DataWidth  downstream response data
- `m_rid`  in  $clog2(NumTags)  downstream response tag
- `err`  out  1  sticky: response arrived for an unallocated tag

## Operation
- Tag table: `NumTags` entries {`valid`, `src` (requester index), `aid`}, registered.
- Free tag = lowest-index entry with `valid`=0 in registered table; `full` when none.
- Arbitration: when not locked and not full, pick first requester with `s_req`=1 scanning from `rr_ptr` upward with wrap. Full → `m_req`=0, all `s_gnt`=0.
- Lock: if `m_req`=1 and `m_gnt`=0, set `locked`, hold `sel` and tag; A-channel fields must stay stable until grant (OBI rule). Cleared on grant.
- A-channel forward: `m_req`=`s_req[sel]`; addr/we/be/wdata from `sel`; `m_aid`=tag; `s_gnt[sel]`=`m_gnt`, others 0.
- On `m_req`&&`m_gnt`: entry[tag] ← {1, sel, `s_aid[sel]`}; `rr_ptr` ← (sel+1) mod `NumReq`.
- R-channel: e=entry[`m_rid`]. If valid: `s_rvalid[e.src]`=`m_rvalid`, `s_rid`=e.aid, `m_rready`=`s_rready[e.src]`; other `s_rvalid`=0. On `m_rvalid`&&`m_rready`, entry ← invalid.
- Invalid `m_rid` with `m_rvalid`: `m_rready`=1 (drain), no `s_rvalid`, `err` ← 1.
- Same-cycle alloc and free: alloc uses pre-cycle table, so a tag freed this cycle is reusable next cycle; both updates apply, no conflict (different tags).
- Requester dropping `s_req` while locked is an OBI protocol violation; not handled.

## Timing
- Reset values: table all invalid, `rr_ptr`=0, `locked`=0, `err`=0; hence `m_req`=0, `s_gnt`=0, `s_rvalid`=0, `m_rready`=0 (with `m_rvalid`=0).
- A channel and R channel: zero-cycle combinational pass-through.
- Tag freed in cycle N is allocatable in cycle N+1.
- Back-to-back grants: one per cycle while tags are free.
- Reset mid-transaction: outstanding tags discarded; late responses afterwards raise `err`.

## Structure
- `xadac_pkg`: tag width/count constants and tag-entry struct type.
- Sub-module `xadac_rr_pick` (parameter `N`): request vector + pointer → one-hot grant + index, combinational; reusable elsewhere.

## Test plan
- Reset, then req0 only, `m_gnt`=1: `m_aid`=0, entry0 {1,0,aid}; response `m_rid`=0 → `s_rvalid[0]`=1, `s_rid`=original aid, tag0 freed.
- Both requesters asserting every cycle, `m_gnt`=1: grants alternate 0,1,0,1; tags 0,1,2,3.
- Req1 with `m_gnt`=0 for 3 cycles while req0 rises: `sel` stays 1, addr stable, grant on cycle 4 goes to req1.
- 8 grants without responses: table full, `m_req`=0; respond `m_rid`=5 → next cycle tag 5 allocated.
- Response `m_rid`=3 with `s_rready[src]`=0 for 2 cycles: `m_rready`=0, entry kept until ready.
- `m_rvalid` with unallocated `m_rid`=6: `m_rready`=1, no `s_rvalid`, `err`=1 until `rst`.
